uart_tx_ctrl: RTL
=================

// Module: uart_tx_ctrl
// PURPOSE
//  Sequencer for the UART transmit PISO shift register. Accepts a byte on a valid/ready
//  handshake, loads the PISO, and frames the serial line: start bit, DATA_W data bits
//  LSB first, optional parity, then 1 or 2 stop bits, each held CLKS_PER_BIT clocks.
//  Sits between the TX byte source (FIFO/CPU) and the PISO + txd pad.
// PARAMETERS
//  CLKS_PER_BIT  868  clocks per bit period (100 MHz / 115200); legal range >= 2
//  DATA_W        8    data bits per frame; must match PISO width
//  PARITY_EN     0    1 = insert parity bit after data bits
//  PARITY_ODD    0    0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0)
//  STOP_BITS     1    number of stop bits, 1 or 2
// PORTS
//  clk         in   1       system clock, rising edge
//  rst         in   1       asynchronous reset, active high
//  tx_valid    in   1       byte source has data on tx_data
//  tx_data     in   DATA_W  byte to send; sampled only on accept
//  tx_ready    out  1       controller idle; accept = tx_valid & tx_ready at a rising edge
//  piso_load   out  1       one-cycle load strobe to the PISO
//  piso_data   out  DATA_W  registered copy of the accepted byte, to the PISO datain
//  piso_shift  out  1       one-cycle shift-enable to the PISO (shift toward LSB)
//  piso_bit    in   1       PISO serial output, the current LSB
//  txd         out  1       UART line; idles high
//  busy        out  1       frame in progress (state != IDLE)
//  frame_done  out  1       one-cycle pulse, last stop bit completed
// BEHAVIOUR
//  - Reset (async): state = IDLE, txd = 1, tx_ready = 1, busy = 0, piso_load = 0,
//    piso_shift = 0, frame_done = 0, piso_data = 0, baud and bit counters = 0.
//  - FSM states: IDLE -> START -> DATA -> [PARITY if PARITY_EN] -> STOP -> IDLE.
//  - Baud tick: the counter clears on accept and on every tick.
//    tick = (cnt == CLKS_PER_BIT-1). Every state transition after IDLE happens on a tick.
//  - Accept at edge E0:
//    - latch piso_data <= tx_data; parity <= ^tx_data ^ PARITY_ODD.
//    - go to START; piso_load = 1 for the single cycle E0..E0+1, so the PISO loads at E0+1.
//  - txd is a combinational decode of registered state only. There is no path from
//    tx_valid or tx_data to txd.
//    - IDLE = 1, START = 0, DATA = piso_bit, PARITY = parity, STOP = 1.
//  - Timing: START spans E0..E0+C (C = CLKS_PER_BIT). Data bit k spans E0+(k+1)C..E0+(k+2)C.
//  - piso_shift = (state == DATA) & tick. This gives DATA_W pulses per frame; the final
//    shift is harmless.
//  - Bit counter counts 0..DATA_W-1 in DATA and 0..STOP_BITS-1 in STOP.
//  - Frame length N = 1 + DATA_W + PARITY_EN + STOP_BITS bit periods.
//    - At edge E0+N*C the FSM returns to IDLE.
//    - frame_done = 1 and tx_ready = 1 in the cycle that follows.
//  - Back-to-back: with tx_valid held high, the next accept happens at E0+N*C+1, so txd
//    idles high for exactly one clock between frames.
//  - tx_ready = 0 in every state except IDLE. tx_valid and tx_data are ignored while busy;
//    changing tx_data mid-frame has no effect.
//  - Reset mid-frame: txd goes to 1 immediately, the frame is aborted, and there is no
//    frame_done pulse. The next accepted byte is framed correctly from START.
// STRUCTURE
//  - uart_defs.vh: FSM state encodings (ST_IDLE/ST_START/ST_DATA/ST_PARITY/ST_STOP),
//    default DATA_W and baud constants, parity mode constants. Shared with the RX side.
//  - Sub-module uart_baud_gen #(CLKS_PER_BIT): clk, rst, clr -> tick. Counter only.
//  - Top level holds the FSM, bit counter, data/parity latch and txd decode.
// TESTING  (CLKS_PER_BIT=4, DATA_W=8, PISO model LSB-first)
//  1. Reset: rst=1 with tx_valid=1 -> txd=1, tx_ready=1, busy=0, load/shift/frame_done=0,
//     no accept.
//  2. Send 8'b01011101, parity off -> txd per 4 clks: 0 | 1,0,1,1,1,0,1,0 | 1.
//     Expect 1 piso_load, 8 piso_shift, frame_done 40 clks after accept.
//  3. PARITY_EN=1 with 0x5D: even -> parity bit 1, odd -> 0. Frame 44 clks.
//     STOP_BITS=2 -> stop held 8 clks.
//  4. tx_valid held with 0xA5 then 0x3C -> second accept 1 clk after frame_done.
//     txd high for exactly 1 clk between frames; both bytes recovered by the line monitor.
//  5. rst pulsed during data bit 3 of 0x5D -> txd=1 asynchronously, no frame_done.
//     A following 0xFF is sent as 0 | 1x8 | 1.
//  6. Toggle tx_data and pulse tx_valid mid-frame -> no second load, frame bits unchanged,
//     tx_ready stays 0 until IDLE.

Source files
------------

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared UART TX definitions: FSM state encoding, default frame/baud constants
// and parity mode values, also used by the receive side.
package uart_tx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int DEF_CLKS_PER_BIT = 868;   // 100 MHz / 115200 baud
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_STOP_BITS    = 1;
    localparam int PARITY_MODE_EVEN = 0;
    localparam int PARITY_MODE_ODD  = 1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake between the TX byte source (FIFO/CPU) and the TX controller.
interface uart_tx_ctrl_if
    import uart_tx_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_ctrl_baud_gen.sv
// Baud counter: tick is high in the last clock of every bit period; clr restarts the period.
module uart_tx_ctrl_baud_gen
    import uart_tx_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
)
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int            CW   = cnt_w(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a byte, loads the external PISO and frames
// start / data (LSB first) / optional parity / stop bits onto txd.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = PARITY_MODE_EVEN,
    parameter int STOP_BITS    = DEF_STOP_BITS
)
(
    input  logic              clk,
    input  logic              rst,
    uart_tx_ctrl_if.slave     tx,
    output logic              piso_load,
    output logic [DATA_W-1:0] piso_data,
    output logic              piso_shift,
    input  logic              piso_bit,
    output logic              txd,
    output logic              busy,
    output logic              frame_done
);
    localparam int            BW        = cnt_w(DATA_W);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    tx_state_e     state;
    logic [BW-1:0] bit_cnt;
    logic          parity;
    logic          accept;
    logic          tick;

    assign accept     = (state == ST_IDLE) && tx.tx_valid;
    assign piso_shift = (state == ST_DATA) && tick;

    uart_tx_ctrl_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .tick (tick)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            parity      <= 1'b0;
            piso_data   <= '0;
            piso_load   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            tx.tx_ready <= 1'b1;
        end else begin
            piso_load  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx.tx_valid) begin
                        piso_data   <= tx.tx_data;
                        parity      <= (^tx.tx_data) ^ (PARITY_ODD != 0);
                        piso_load   <= 1'b1;
                        bit_cnt     <= '0;
                        busy        <= 1'b1;
                        tx.tx_ready <= 1'b0;
                        state       <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick)
                        state <= ST_DATA;
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick)
                        state <= ST_STOP;
                end
                ST_STOP: begin
                    if (tick) begin
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt     <= '0;
                            busy        <= 1'b0;
                            frame_done  <= 1'b1;
                            tx.tx_ready <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The line depends on registered state only, never on tx_valid/tx_data.
    always_comb begin
        // NOTE: default assignment first, so no path leaves txd unassigned and no latch is inferred.
        txd = 1'b1;
        case (state)
            ST_START:  txd = 1'b0;
            ST_DATA:   txd = piso_bit;
            ST_PARITY: txd = parity;
            default:   txd = 1'b1;
        endcase
    end
endmodule
